// File: rtl/apb_cfg_pkg.sv
// Shared constants and types for the APB configuration completer.
// Falls back to the link-wide APB maxima when the agent defines are not already present.
`ifndef AY_APB_MAX_ADDR_WIDTH
`define AY_APB_MAX_ADDR_WIDTH 16
`endif
`ifndef AY_APB_MAX_DATA_WIDTH
`define AY_APB_MAX_DATA_WIDTH 32
`endif

package apb_cfg_pkg;

   localparam int unsigned ADDR_CTRL     = 32'h0000_0000;
   localparam int unsigned ADDR_STATUS   = 32'h0000_0008;
   localparam int unsigned ADDR_IRQ_EN   = 32'h0000_00F0;
   localparam int unsigned ADDR_IRQ_STAT = 32'h0000_00F4;

   // Wide enough for WAIT_STATES in 0..7
   localparam int unsigned WAIT_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_cmp_state_e;

endpackage

// File: rtl/apb_cfg_regfile.sv
// Register storage, address decode, error generation and interrupt set/W1C logic
// for the aligner core configuration space.
module apb_cfg_regfile
   import apb_cfg_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = `AY_APB_MAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = `AY_APB_MAX_DATA_WIDTH,
   parameter int unsigned IRQ_W      = 5
) (
   input  logic                  clk,
   input  logic                  preset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] status_i,
   input  logic [IRQ_W-1:0]      irq_set_i,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] ctrl_o,
   output logic                  irq_o
);

   logic [DATA_WIDTH-1:0] ctrl_q;
   logic [IRQ_W-1:0]      irq_en_q;
   logic [IRQ_W-1:0]      irq_stat_q;
   logic [IRQ_W-1:0]      irq_clr;
   logic                  hit_ctrl, hit_status, hit_irq_en, hit_irq_stat;

   // Full-width compares: no aliasing of the map into higher addresses
   assign hit_ctrl     = (addr == ADDR_WIDTH'(ADDR_CTRL));
   assign hit_status   = (addr == ADDR_WIDTH'(ADDR_STATUS));
   assign hit_irq_en   = (addr == ADDR_WIDTH'(ADDR_IRQ_EN));
   assign hit_irq_stat = (addr == ADDR_WIDTH'(ADDR_IRQ_STAT));

   always_comb begin
      rdata = '0;
      err   = 1'b0;
      if (addr[1:0] != 2'b00) begin
         err = 1'b1;
      end else if (hit_ctrl) begin
         rdata = ctrl_q;
      end else if (hit_status) begin
         rdata = status_i;
         err   = wr;
      end else if (hit_irq_en) begin
         rdata = DATA_WIDTH'(irq_en_q);
      end else if (hit_irq_stat) begin
         rdata = DATA_WIDTH'(irq_stat_q);
      end else begin
         err = 1'b1;
      end
   end

   assign irq_clr = (we && hit_irq_stat) ? wdata[IRQ_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (preset) begin
         ctrl_q     <= '0;
         irq_en_q   <= '0;
         irq_stat_q <= '0;
      end else begin
         if (we && hit_ctrl) begin
            ctrl_q <= wdata;
         end
         if (we && hit_irq_en) begin
            irq_en_q <= wdata[IRQ_W-1:0];
         end
         // A new event outranks a simultaneous W1C clear of the same bit
         irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set_i;
      end
   end

   assign ctrl_o = ctrl_q;
   assign irq_o  = |(irq_stat_q & irq_en_q);

endmodule

// File: rtl/apb_cfg_completer.sv
// APB completer for the aligner core configuration space: transfer FSM, programmable
// wait states, request latching and registered pready/prdata/pslverr.
module apb_cfg_completer
   import apb_cfg_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = `AY_APB_MAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = `AY_APB_MAX_DATA_WIDTH,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned IRQ_W       = 5
) (
   input  logic                  clk,
   input  logic                  preset,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic                  pwrite,
   input  logic                  psel,
   input  logic                  penable,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pready,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pslverr,
   input  logic [DATA_WIDTH-1:0] status_i,
   input  logic [IRQ_W-1:0]      irq_set_i,
   output logic [DATA_WIDTH-1:0] ctrl_o,
   output logic                  irq_o
);

   apb_cmp_state_e        state_q, state_d, state_eff;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  pready_q, pready_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pslverr_q, pslverr_d;
   logic                  reg_we;
   logic [DATA_WIDTH-1:0] rf_rdata;
   logic                  rf_err;

   always_comb begin
      // SETUP coincides with the bus setup cycle so that pready lands at S+2+WAIT_STATES
      state_eff = state_q;
      if ((state_q == IDLE || state_q == RESP) && psel && !penable) begin
         state_eff = SETUP;
      end

      state_d   = IDLE;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      reg_we    = 1'b0;

      case (state_eff)
         IDLE: begin
            state_d = IDLE;
         end
         SETUP: begin
            addr_d  = paddr;
            wr_d    = pwrite;
            wdata_d = pwdata;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
            state_d = ACCESS;
         end
         ACCESS: begin
            if (psel && penable) begin
               if (cnt_q != '0) begin
                  cnt_d   = cnt_q - WAIT_CNT_W'(1);
                  state_d = ACCESS;
               end else begin
                  pready_d  = 1'b1;
                  pslverr_d = rf_err;
                  prdata_d  = (rf_err || wr_q) ? '0 : rf_rdata;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            reg_we  = psel && penable && wr_q && !pslverr_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (preset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   apb_cfg_regfile #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IRQ_W      (IRQ_W)
   ) u_regfile (
      .clk       (clk),
      .preset    (preset),
      .addr      (addr_q),
      .wr        (wr_q),
      .wdata     (wdata_q),
      .we        (reg_we),
      .status_i  (status_i),
      .irq_set_i (irq_set_i),
      .rdata     (rf_rdata),
      .err       (rf_err),
      .ctrl_o    (ctrl_o),
      .irq_o     (irq_o)
   );

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_cfg_completer.sv
// Self-checking bench: two completers (0 and 3 wait states) on a shared APB bus,
// table-driven transfers with a response scoreboard plus IRQ, back-to-back and reset sequences.
module tb_apb_cfg_completer;

   logic        clk = 1'b0;
   logic        preset;
   logic [15:0] paddr;
   logic        pwrite, penable, psel0, psel3;
   logic [31:0] pwdata, status;
   logic [4:0]  irq_set;
   logic        pready0, pslverr0, irq0, pready3, pslverr3, irq3;
   logic [31:0] prdata0, ctrl0, prdata3, ctrl3;

   always #5 clk = ~clk;

   apb_cfg_completer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(0), .IRQ_W(5)) u_dut0 (
      .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel0),
      .penable(penable), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
      .pslverr(pslverr0), .status_i(status), .irq_set_i(irq_set), .ctrl_o(ctrl0), .irq_o(irq0)
   );

   apb_cfg_completer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(3), .IRQ_W(5)) u_dut3 (
      .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite), .psel(psel3),
      .penable(penable), .pwdata(pwdata), .pready(pready3), .prdata(prdata3),
      .pslverr(pslverr3), .status_i(status), .irq_set_i(irq_set), .ctrl_o(ctrl3), .irq_o(irq3)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      int          d;
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_ctrl;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];
   exp_t q0[$];
   exp_t q3[$];
   exp_t e0, e3;
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboards: a response is popped only when its completer raises pready
   always @(posedge clk) begin
      #1;
      if (pready0 === 1'b1) begin
         if (q0.size() == 0) begin
            check("dut0_unexpected_pready", 32'(pready0), 32'd0);
         end else begin
            e0 = q0.pop_front();
            check("dut0_prdata", prdata0, e0.rdata);
            check("dut0_pslverr", 32'(pslverr0), 32'(e0.err));
         end
      end else begin
         check("dut0_idle_out", prdata0 | 32'(pslverr0), 32'd0);
      end
   end

   always @(posedge clk) begin
      #1;
      if (pready3 === 1'b1) begin
         if (q3.size() == 0) begin
            check("dut3_unexpected_pready", 32'(pready3), 32'd0);
         end else begin
            e3 = q3.pop_front();
            check("dut3_prdata", prdata3, e3.rdata);
            check("dut3_pslverr", 32'(pslverr3), 32'(e3.err));
         end
      end else begin
         check("dut3_idle_out", prdata3 | 32'(pslverr3), 32'd0);
      end
   end

   // Leaves the bus in the access phase during the pready cycle so a following
   // xfer call starts its setup immediately (back-to-back).
   task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
      int   n;
      int   lat;
      exp_t e;
      lat     = (d == 0) ? 0 : 3;
      e.rdata = er;
      e.err   = ee;
      @(posedge clk); #1;
      psel0   = (d == 0);
      psel3   = (d != 0);
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      if (d == 0) q0.push_back(e);
      else q3.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      n = 1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!((d == 0) ? pready0 : pready3) && n < 20);
      check($sformatf("latency_dut%0d_%04h", d, a), 32'(n), 32'(2 + lat));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         psel0   = 1'b0;
         psel3   = 1'b0;
         penable = 1'b0;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{0, 1'b1, 16'h0000, 32'hA5A5_0001, 32'h0,         1'b0, 32'hA5A5_0001};
      vecs[1]  = '{0, 1'b0, 16'h0000, 32'h0,         32'hA5A5_0001, 1'b0, 32'hA5A5_0001};
      vecs[2]  = '{3, 1'b0, 16'h0008, 32'h0,         32'h0000_1234, 1'b0, 32'h0};
      vecs[3]  = '{3, 1'b1, 16'h0008, 32'h1,         32'h0,         1'b1, 32'h0};
      vecs[4]  = '{3, 1'b0, 16'h0008, 32'h0,         32'h0000_1234, 1'b0, 32'h0};
      vecs[5]  = '{3, 1'b1, 16'h0000, 32'h55,        32'h0,         1'b0, 32'h55};
      vecs[6]  = '{0, 1'b1, 16'h0004, 32'hDEAD_BEEF, 32'h0,         1'b1, 32'hA5A5_0001};
      vecs[7]  = '{0, 1'b1, 16'h00F2, 32'hDEAD_BEEF, 32'h0,         1'b1, 32'hA5A5_0001};
      vecs[8]  = '{0, 1'b0, 16'h0100, 32'h0,         32'h0,         1'b1, 32'hA5A5_0001};
      vecs[9]  = '{0, 1'b0, 16'h0002, 32'h0,         32'h0,         1'b1, 32'hA5A5_0001};
      vecs[10] = '{0, 1'b1, 16'h00F0, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'hA5A5_0001};
      vecs[11] = '{0, 1'b0, 16'h00F0, 32'h0,         32'h0000_001F, 1'b0, 32'hA5A5_0001};
      vecs[12] = '{0, 1'b0, 16'h00F4, 32'h0,         32'h0,         1'b0, 32'hA5A5_0001};

      preset  = 1'b1;
      paddr   = '0;
      pwrite  = 1'b0;
      penable = 1'b0;
      psel0   = 1'b0;
      psel3   = 1'b0;
      pwdata  = '0;
      status  = 32'h0000_1234;
      irq_set = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready0", 32'(pready0), 32'd0);
      check("rst_ctrl0", ctrl0, 32'd0);
      check("rst_irq0", 32'(irq0), 32'd0);
      check("rst_pready3", 32'(pready3), 32'd0);
      check("rst_ctrl3", ctrl3, 32'd0);
      check("rst_irq3", 32'(irq3), 32'd0);
      preset = 1'b0;
      idle(2);

      for (int i = 0; i < NV; i++) begin
         xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
              vecs[i].exp_err);
         idle(1);
         check($sformatf("ctrl_after_vec%0d", i), (vecs[i].d == 0) ? ctrl0 : ctrl3,
               vecs[i].exp_ctrl);
      end

      // Interrupt set, set-beats-clear, then full clear
      @(posedge clk); #1;
      irq_set = 5'h05;
      @(posedge clk); #1;
      irq_set = 5'h00;
      check("irq0_after_set", 32'(irq0), 32'd1);
      check("irq3_masked", 32'(irq3), 32'd0);
      xfer(0, 1'b0, 16'h00F4, 32'h0, 32'h05, 1'b0);
      idle(1);
      irq_set = 5'h04;
      xfer(0, 1'b1, 16'h00F4, 32'h04, 32'h0, 1'b0);
      @(posedge clk); #1;
      irq_set = 5'h00;
      psel0   = 1'b0;
      penable = 1'b0;
      check("irq0_set_wins", 32'(irq0), 32'd1);
      xfer(0, 1'b0, 16'h00F4, 32'h0, 32'h05, 1'b0);
      idle(1);
      xfer(0, 1'b1, 16'h00F4, 32'h05, 32'h0, 1'b0);
      idle(1);
      check("irq0_cleared", 32'(irq0), 32'd0);
      xfer(0, 1'b0, 16'h00F4, 32'h0, 32'h0, 1'b0);
      idle(1);

      // Back-to-back write then read with no idle bus cycle
      xfer(0, 1'b1, 16'h0000, 32'h1, 32'h0, 1'b0);
      xfer(0, 1'b0, 16'h0000, 32'h0, 32'h1, 1'b0);
      idle(1);
      check("ctrl0_b2b", ctrl0, 32'h1);

      // Reset during the access phase of a CTRL write on the wait-state completer
      @(posedge clk); #1;
      psel3   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 16'h0000;
      pwdata  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      preset = 1'b1;
      @(posedge clk); #1;
      preset  = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
      check("ctrl3_after_abort", ctrl3, 32'd0);
      check("ctrl0_after_reset", ctrl0, 32'd0);
      idle(6);
      check("ctrl3_no_late_commit", ctrl3, 32'd0);
      xfer(3, 1'b1, 16'h0000, 32'h77, 32'h0, 1'b0);
      xfer(3, 1'b0, 16'h0000, 32'h0, 32'h77, 1'b0);
      idle(1);
      check("ctrl3_after_recover", ctrl3, 32'h77);

      idle(2);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q3_drained", 32'(q3.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
